// File: rtl/wb_bus_scheduler_pkg.sv
// rtl/wb_bus_scheduler_pkg.sv - shared wishbone widths and master request bundle
package wb_bus_scheduler_pkg;

  localparam int WB_DATA_W   = 16;
  localparam int WB_ADDR_W   = 24;
  localparam int WB_SEL_BITS = 2;

  typedef struct packed {
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [WB_ADDR_W-1:0]   adr;
    logic [WB_DATA_W-1:0]   dat;
    logic [WB_SEL_BITS-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_bus_scheduler_watchdog.sv
// rtl/wb_bus_scheduler_watchdog.sv - counts unanswered strobe cycles, flags abort at TIMEOUT
module wb_bus_scheduler_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic stb,
  input  logic resp,
  output logic abort
);

  logic [CNT_W-1:0] wd_cnt;
  logic             at_limit;

  assign at_limit = (wd_cnt == CNT_W'(TIMEOUT));

  // A response on the limit cycle wins over the abort.
  assign abort = !clear && stb && !resp && at_limit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt <= '0;
    end else if (clear || resp) begin
      wd_cnt <= '0;
    end else if (stb && !at_limit) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_bus_scheduler.sv
// rtl/wb_bus_scheduler.sv - two-master wishbone arbiter: data priority, fetch anti-starvation, watchdog abort
module wb_bus_scheduler
  import wb_bus_scheduler_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   m0_cyc,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  input  logic [WB_ADDR_W-1:0]   m0_adr,
  input  logic [WB_DATA_W-1:0]   m0_dat,
  input  logic [WB_SEL_BITS-1:0] m0_sel,
  output logic                   m0_ack,
  output logic                   m0_err,
  output logic                   m0_rty,
  input  logic                   m1_cyc,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  input  logic [WB_ADDR_W-1:0]   m1_adr,
  input  logic [WB_DATA_W-1:0]   m1_dat,
  input  logic [WB_SEL_BITS-1:0] m1_sel,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic                   m1_rty,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [WB_ADDR_W-1:0]   wb_adr,
  output logic [WB_DATA_W-1:0]   wb_o_dat,
  output logic [WB_SEL_BITS-1:0] wb_sel,
  input  logic                   wb_ack,
  input  logic                   wb_err,
  input  logic                   wb_rty,
  output logic [1:0]             o_grant,
  output logic                   o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_G0    = 2'd1;
  localparam logic [1:0] S_G1    = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          abort_owner;

  wb_req_t req0;
  wb_req_t req1;
  wb_req_t cur;

  logic in_g0;
  logic in_g1;
  logic owned;
  logic resp;
  logic abort;
  logic owner_cyc;
  logic starved;

  assign req0 = '{cyc: m0_cyc, stb: m0_stb, we: m0_we, adr: m0_adr, dat: m0_dat, sel: m0_sel};
  assign req1 = '{cyc: m1_cyc, stb: m1_stb, we: m1_we, adr: m1_adr, dat: m1_dat, sel: m1_sel};

  assign in_g0 = (state == S_G0);
  assign in_g1 = (state == S_G1);
  assign owned = in_g0 || in_g1;
  assign cur   = in_g1 ? req1 : req0;
  assign resp  = wb_ack || wb_err || wb_rty;

  assign starved = (starve_cnt == SW'(STARVE_LIM));

  wb_bus_scheduler_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clear (!owned),
    .stb   (owned && cur.stb),
    .resp  (resp),
    .abort (abort)
  );

  // Bus mux follows the registered state; owner dropping cyc releases the bus immediately.
  assign wb_cyc   = owned && cur.cyc && !abort;
  assign wb_stb   = owned && cur.stb && !abort;
  assign wb_we    = owned && cur.we;
  assign wb_adr   = owned ? cur.adr : '0;
  assign wb_o_dat = owned ? cur.dat : '0;
  assign wb_sel   = owned ? cur.sel : '0;

  assign m0_ack = in_g0 && wb_ack;
  assign m0_err = in_g0 && (wb_err || abort);
  assign m0_rty = in_g0 && wb_rty;
  assign m1_ack = in_g1 && wb_ack;
  assign m1_err = in_g1 && (wb_err || abort);
  assign m1_rty = in_g1 && wb_rty;

  assign o_grant   = {in_g1, in_g0};
  assign o_timeout = abort;

  assign owner_cyc = abort_owner ? m1_cyc : m0_cyc;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (m1_cyc && (!m0_cyc || starved)) begin
          state_nxt = S_G1;
        end else if (m0_cyc) begin
          state_nxt = S_G0;
        end
      end
      S_G0, S_G1: begin
        if (abort) begin
          state_nxt = cur.cyc ? S_ABORT : S_IDLE;
        end else if (!cur.cyc) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        if (!owner_cyc) begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      starve_cnt  <= '0;
      abort_owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        abort_owner <= in_g1;
      end
      // Starvation count only moves on grant entry.
      if (state == S_IDLE) begin
        if (state_nxt == S_G1) begin
          starve_cnt <= '0;
        end else if (state_nxt == S_G0) begin
          if (!m1_cyc) begin
            starve_cnt <= '0;
          end else if (!starved) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_bus_scheduler.sv
// tb/tb_wb_bus_scheduler.sv - directed self-checking bench for wb_bus_scheduler
module tb_wb_bus_scheduler;

  logic        i_clk;
  logic        i_rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [23:0] m0_adr;
  logic [15:0] m0_dat;
  logic [1:0]  m0_sel;
  logic        m0_ack, m0_err, m0_rty;
  logic        m1_cyc, m1_stb, m1_we;
  logic [23:0] m1_adr;
  logic [15:0] m1_dat;
  logic [1:0]  m1_sel;
  logic        m1_ack, m1_err, m1_rty;
  logic        wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_o_dat;
  logic [1:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty;
  logic [1:0]  o_grant;
  logic        o_timeout;

  int n_checks;
  int n_fail;

  wb_bus_scheduler #(.STARVE_LIM(4), .TIMEOUT(255), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat(m0_dat), .m0_sel(m0_sel),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat(m1_dat), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_o_dat(wb_o_dat), .wb_sel(wb_sel),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic m0_req(input logic on);
    m0_cyc = on;
    m0_stb = on;
  endtask

  task automatic m1_req(input logic on);
    m1_cyc = on;
    m1_stb = on;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst  = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 1'b1; m0_adr = 24'h123456; m0_dat = 16'hA5A5; m0_sel = 2'b11;
    m1_cyc = 0; m1_stb = 0; m1_we = 1'b0; m1_adr = 24'h00ABCD; m1_dat = 16'h5A5A; m1_sel = 2'b01;
    wb_ack = 0; wb_err = 0; wb_rty = 0;

    repeat (2) @(posedge i_clk);
    #2;
    check("rst_grant", o_grant, 2'b00);
    check("rst_cyc", wb_cyc, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_tmo", o_timeout, 0);
    i_rst = 1'b0;

    // Priority: both request together, data wins
    tick();
    m0_req(1); m1_req(1);
    #1 check("prio_idle_grant", o_grant, 2'b00);
    for (int b = 0; b < 3; b++) begin
      tick();
      wb_ack = 1;
      #1;
      check("prio_grant", o_grant, 2'b01);
      check("prio_m0_ack", m0_ack, 1);
      check("prio_m1_ack", m1_ack, 0);
      check("prio_adr", wb_adr, 24'h123456);
      check("prio_dat", wb_o_dat, 16'hA5A5);
    end
    tick();
    m0_req(0); wb_ack = 0;
    #1 check("prio_drop_cyc", wb_cyc, 0);
    tick();
    #1 check("prio_gap_grant", o_grant, 2'b00);
    check("prio_gap_cyc", wb_cyc, 0);
    tick();
    #1 check("prio_m1_grant", o_grant, 2'b10);
    check("prio_m1_adr", wb_adr, 24'h00ABCD);
    check("prio_m1_sel", wb_sel, 2'b01);

    // Atomic burst: m1 keeps cyc for 8 acked beats with m0 waiting
    m0_req(1);
    for (int b = 0; b < 8; b++) begin
      if (b > 0) tick();
      wb_ack = 1;
      #1;
      check("burst_grant", o_grant, 2'b10);
      check("burst_m1_ack", m1_ack, 1);
      check("burst_m0_ack", m0_ack, 0);
    end
    tick();
    m1_req(0); wb_ack = 0;
    #1;
    tick();
    #1 check("burst_idle", o_grant, 2'b00);
    tick();
    #1 check("burst_m0_next", o_grant, 2'b01);
    m0_req(0);
    tick();
    #1 check("burst_end_idle", o_grant, 2'b00);

    // Starvation: m0 re-requests back-to-back while m1 waits
    m0_req(1); m1_req(1);
    for (int g = 0; g < 4; g++) begin
      tick();
      wb_ack = 1;
      #1 check("starve_m0_win", o_grant, 2'b01);
      check("starve_cnt_up", dut.starve_cnt, g + 1);
      tick();
      m0_req(0); wb_ack = 0;
      #1;
      tick();
      m0_req(1);
      #1 check("starve_gap", o_grant, 2'b00);
    end
    tick();
    #1 check("starve_m1_win", o_grant, 2'b10);
    check("starve_cnt_clr", dut.starve_cnt, 0);
    m0_req(0); m1_req(0);
    tick();
    #1;

    // Timeout: m0 strobes with no response
    m0_req(1);
    for (int k = 0; k < 256; k++) begin
      tick();
      #1;
      if (k == 0) check("tmo_grant", o_grant, 2'b01);
      if (k == 254) check("tmo_early", o_timeout, 0);
      if (k == 255) begin
        check("tmo_pulse", o_timeout, 1);
        check("tmo_m0_err", m0_err, 1);
        check("tmo_wb_cyc", wb_cyc, 0);
        check("tmo_wb_stb", wb_stb, 0);
      end
    end
    m1_req(1);
    tick();
    #1 check("abort_grant", o_grant, 2'b00);
    check("abort_cyc", wb_cyc, 0);
    check("abort_err", m0_err, 0);
    check("abort_tmo", o_timeout, 0);
    tick();
    #1 check("abort_hold", o_grant, 2'b00);
    m0_req(0);
    tick();
    #1 check("abort_to_idle", o_grant, 2'b00);
    tick();
    #1 check("abort_m1_served", o_grant, 2'b10);
    m1_req(0);
    tick();
    #1;

    // Race: ack lands on the limit cycle
    m0_req(1);
    for (int k = 0; k < 256; k++) begin
      tick();
      wb_ack = (k == 255);
      #1;
    end
    check("race_ack", m0_ack, 1);
    check("race_err", m0_err, 0);
    check("race_tmo", o_timeout, 0);
    check("race_cyc", wb_cyc, 1);
    tick();
    wb_ack = 0;
    #1 check("race_still_g0", o_grant, 2'b01);

    // Asynchronous reset in the middle of a grant
    #2 i_rst = 1'b1;
    #1 check("arst_cyc", wb_cyc, 0);
    check("arst_grant", o_grant, 2'b00);
    m0_req(0);
    tick();
    i_rst = 1'b0;
    tick();
    #1 check("arst_idle", o_grant, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
